// File: rtl/number_entry.sv
// Debounced keypad number entry: qualifies one press per key stroke and builds
// a DIGITS-wide BCD number plus its registered binary value.
module number_entry #(
  parameter int         DIGITS    = 3,
  parameter int         DEBOUNCE  = 100000,
  parameter int         WRAP_MODE = 1,
  parameter logic [4:0] IDLE_CODE = 5'd17,
  localparam int        W         = $clog2(10 ** DIGITS),
  localparam int        CW        = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rest_n,
  input  logic                clr,
  input  logic [4:0]          key_value,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [W-1:0]        out_d_number,
  output logic [CW-1:0]       digit_cnt,
  output logic                full,
  output logic                key_accept,
  output logic [1:0]          dbg_state
);

  localparam int             BW     = 4 * DIGITS;
  localparam int             CNTW   = $clog2(DEBOUNCE + 1);
  localparam logic [CNTW-1:0] DEB_M1 = CNTW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CNT = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CNT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [4:0]      code_q, code_d;
  logic            accept_d;

  logic [BW-1:0]   bcd_d;
  logic [CW-1:0]   dcnt_d;
  logic [W-1:0]    bin;

  logic            is_digit, is_clear, is_bs;
  logic [3:0]      digit;

  assign dbg_state = state_q;
  assign full      = (digit_cnt == CW'(DIGITS));

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      code_q     <= IDLE_CODE;
      key_accept <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      key_accept <= accept_d;
    end
  end

  // The press counter also times the release, so a key can only be accepted
  // again after a fully qualified idle period.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    accept_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_value != IDLE_CODE) begin
          state_d = ST_PRESS_CNT;
          code_d  = key_value;
          cnt_d   = CNTW'(1);
        end
      end
      ST_PRESS_CNT: begin
        if (key_value == IDLE_CODE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (key_value != code_q) begin
          code_d = key_value;
          cnt_d  = CNTW'(1);
        end else if (cnt_q == DEB_M1) begin
          state_d  = ST_HELD;
          cnt_d    = '0;
          accept_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_HELD: begin
        if (key_value == IDLE_CODE) begin
          state_d = ST_REL_CNT;
          cnt_d   = CNTW'(1);
        end
      end
      ST_REL_CNT: begin
        if (key_value != IDLE_CODE) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_M1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // code_q equals key_value on the qualifying cycle, so decode the latched copy.
  always_comb begin
    is_digit = 1'b1;
    is_clear = 1'b0;
    is_bs    = 1'b0;
    digit    = 4'd0;
    case (code_q)
      5'd13: digit = 4'd0;
      5'd8:  digit = 4'd1;
      5'd9:  digit = 4'd2;
      5'd10: digit = 4'd3;
      5'd4:  digit = 4'd4;
      5'd5:  digit = 4'd5;
      5'd6:  digit = 4'd6;
      5'd0:  digit = 4'd7;
      5'd1:  digit = 4'd8;
      5'd2:  digit = 4'd9;
      5'd12: begin
        is_digit = 1'b0;
        is_clear = 1'b1;
      end
      5'd14: begin
        is_digit = 1'b0;
        is_bs    = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    bcd_d  = out_bcd;
    dcnt_d = digit_cnt;
    if (clr) begin
      bcd_d  = '0;
      dcnt_d = '0;
    end else if (accept_d) begin
      if (is_digit) begin
        if (!(digit_cnt == '0 && digit == 4'd0)) begin
          if (!full) begin
            bcd_d  = (out_bcd << 4) | BW'(digit);
            dcnt_d = digit_cnt + CW'(1);
          end else if (WRAP_MODE != 0) begin
            bcd_d = (out_bcd << 4) | BW'(digit);
          end
        end
      end else if (is_clear) begin
        bcd_d  = '0;
        dcnt_d = '0;
      end else if (is_bs && digit_cnt != '0) begin
        bcd_d  = out_bcd >> 4;
        dcnt_d = digit_cnt - CW'(1);
      end
    end
  end

  // Horner evaluation, most significant digit first.
  always_comb begin
    bin = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      bin = bin * W'(10) + W'(out_bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      out_bcd      <= '0;
      digit_cnt    <= '0;
      out_d_number <= '0;
    end else begin
      out_bcd      <= bcd_d;
      digit_cnt    <= dcnt_d;
      out_d_number <= bin;
    end
  end

endmodule

// File: tb/tb_number_entry.sv
// Directed bench for number_entry (DIGITS=3, DEBOUNCE=4) with a wrapping and a
// non-wrapping instance driven by the same keypad stimulus.
module tb_number_entry;

  localparam logic [4:0] IDLE = 5'd17;

  logic        clk = 1'b0;
  logic        rest_n = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  key_value = IDLE;

  logic [11:0] out_bcd, nw_bcd;
  logic [9:0]  out_d_number, nw_d_number;
  logic [1:0]  digit_cnt, nw_digit_cnt;
  logic        full, nw_full;
  logic        key_accept, nw_key_accept;
  logic [1:0]  dbg_state, nw_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  number_entry #(.DIGITS(3), .DEBOUNCE(4), .WRAP_MODE(1), .IDLE_CODE(5'd17)) dut (
    .clk(clk), .rest_n(rest_n), .clr(clr), .key_value(key_value),
    .out_bcd(out_bcd), .out_d_number(out_d_number), .digit_cnt(digit_cnt),
    .full(full), .key_accept(key_accept), .dbg_state(dbg_state)
  );

  number_entry #(.DIGITS(3), .DEBOUNCE(4), .WRAP_MODE(0), .IDLE_CODE(5'd17)) dut_nw (
    .clk(clk), .rest_n(rest_n), .clr(clr), .key_value(key_value),
    .out_bcd(nw_bcd), .out_d_number(nw_d_number), .digit_cnt(nw_digit_cnt),
    .full(nw_full), .key_accept(nw_key_accept), .dbg_state(nw_dbg_state)
  );

  // A pulse spans one full period, so exactly one falling edge sees it.
  always @(negedge clk) begin
    if (key_accept) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one code for one rising edge; returns just after the next falling edge.
  task automatic tick(input logic [4:0] code);
    key_value = code;
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] code, input int n);
    for (int i = 0; i < n; i++) tick(code);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_bcd", 32'(out_bcd), 32'h0);
    check("rst_num", 32'(out_d_number), 32'd0);
    check("rst_cnt", 32'(digit_cnt), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_accept", 32'(key_accept), 32'd0);
    rest_n = 1'b1;

    // 1, 2, 3 entered with long holds
    press(5'd8, 10);
    press(IDLE, 5);
    press(5'd9, 10);
    press(IDLE, 5);
    check("seq_bcd12", 32'(out_bcd), 32'h012);
    press(5'd10, 3);
    check("seq_no_early_acc", 32'(key_accept), 32'd0);
    press(5'd10, 1);
    check("seq_acc_pulse", 32'(key_accept), 32'd1);
    check("seq_bcd123", 32'(out_bcd), 32'h123);
    check("seq_num_lag", 32'(out_d_number), 32'd12);
    press(5'd10, 1);
    check("seq_acc_end", 32'(key_accept), 32'd0);
    check("seq_num123", 32'(out_d_number), 32'd123);
    press(5'd10, 5);
    press(IDLE, 5);
    check("seq_acc_count", 32'(acc_cnt), 32'd3);
    check("seq_cnt", 32'(digit_cnt), 32'd3);
    check("seq_full", 32'(full), 32'd1);
    check("nw_bcd123", 32'(nw_bcd), 32'h123);

    // wrap versus reject when full
    press(5'd4, 4);
    check("wrap_bcd", 32'(out_bcd), 32'h234);
    check("wrap_full", 32'(full), 32'd1);
    check("nw_reject_bcd", 32'(nw_bcd), 32'h123);
    check("nw_reject_acc", 32'(nw_key_accept), 32'd1);
    press(5'd4, 2);
    press(IDLE, 5);

    // backspace, clear, leading zero, ignored key
    press(5'd14, 4);
    press(IDLE, 5);
    check("bs_bcd", 32'(out_bcd), 32'h023);
    check("bs_cnt", 32'(digit_cnt), 32'd2);
    check("bs_num", 32'(out_d_number), 32'd23);
    check("bs_full", 32'(full), 32'd0);
    press(5'd12, 4);
    press(IDLE, 5);
    check("clear_bcd", 32'(out_bcd), 32'h0);
    check("clear_cnt", 32'(digit_cnt), 32'd0);
    press(5'd13, 4);
    check("lead0_acc", 32'(key_accept), 32'd1);
    check("lead0_bcd", 32'(out_bcd), 32'h0);
    check("lead0_cnt", 32'(digit_cnt), 32'd0);
    press(IDLE, 5);
    press(5'd14, 4);
    check("bs_empty_cnt", 32'(digit_cnt), 32'd0);
    press(IDLE, 5);
    press(5'd7, 4);
    check("ignored_acc", 32'(key_accept), 32'd1);
    check("ignored_bcd", 32'(out_bcd), 32'h0);
    press(IDLE, 5);
    check("pre_bounce_count", 32'(acc_cnt), 32'd9);

    // bounce: short presses never qualify
    press(5'd5, 3);
    press(IDLE, 1);
    press(5'd5, 3);
    press(IDLE, 1);
    check("bounce_count", 32'(acc_cnt), 32'd9);
    press(5'd5, 4);
    check("bounce_bcd", 32'(out_bcd), 32'h005);
    check("bounce_cnt", 32'(digit_cnt), 32'd1);
    press(IDLE, 5);
    check("bounce_one_acc", 32'(acc_cnt), 32'd10);

    // code change restarts qualification; release bounce gives no repeat
    press(5'd6, 2);
    press(5'd0, 3);
    check("roll_no_acc", 32'(out_bcd), 32'h005);
    press(5'd0, 1);
    check("roll_bcd", 32'(out_bcd), 32'h057);
    press(IDLE, 5);
    press(5'd1, 4);
    press(IDLE, 2);
    press(5'd1, 3);
    press(IDLE, 5);
    check("rel_bounce_bcd", 32'(out_bcd), 32'h578);
    check("rel_bounce_count", 32'(acc_cnt), 32'd12);
    check("nw_578", 32'(nw_bcd), 32'h578);

    // clr wins over a simultaneous accept; held key is not re-accepted
    press(5'd9, 3);
    clr = 1'b1;
    tick(5'd9);
    clr = 1'b0;
    check("clr_bcd", 32'(out_bcd), 32'h0);
    check("clr_cnt", 32'(digit_cnt), 32'd0);
    check("clr_acc", 32'(key_accept), 32'd1);
    press(5'd9, 8);
    check("clr_hold_bcd", 32'(out_bcd), 32'h0);
    check("clr_hold_count", 32'(acc_cnt), 32'd13);
    press(IDLE, 5);

    // asynchronous reset in the middle of a press count
    press(5'd4, 4);
    press(IDLE, 5);
    press(5'd5, 4);
    press(IDLE, 5);
    check("pre_rst_bcd", 32'(out_bcd), 32'h045);
    press(5'd6, 2);
    #2;
    rest_n = 1'b0;
    #1;
    check("arst_bcd", 32'(out_bcd), 32'h0);
    check("arst_num", 32'(out_d_number), 32'd0);
    check("arst_cnt", 32'(digit_cnt), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    check("arst_acc", 32'(key_accept), 32'd0);
    @(negedge clk);
    #1;
    rest_n = 1'b1;
    press(5'd6, 3);
    check("arst_requal_wait", 32'(out_bcd), 32'h0);
    check("arst_requal_acc0", 32'(key_accept), 32'd0);
    press(5'd6, 1);
    check("arst_requal_acc", 32'(key_accept), 32'd1);
    check("arst_requal_bcd", 32'(out_bcd), 32'h006);
    press(IDLE, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
